// File: rtl/md_seq_ctrl.sv
// Sequencing controller for the multi-cycle mult/div unit. It runs the latency counter,
// generates busy and the HI/LO write strobe, and merges the md stall with the hazard stall.
module md_seq_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [1:0] mdop,
    input  logic       divisor_zero,
    input  logic       mt_we,
    input  logic       usemd_d,
    input  logic       hazard_stall,
    output logic       busy,
    output logic       result_we,
    output logic [1:0] op_q,
    output logic       stall_f,
    output logic       stall_d,
    output logic       bubble_e,
    output logic       seq_err
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_load_d;
    logic             divz_q;
    logic             seq_err_q;
    logic             last_d;
    logic             md_stall;

    assign cnt_load_d = mdop[1] ? DIV_LOAD : MULT_LOAD;
    assign last_d     = (cnt_q == CNT_ONE);

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 2'b00;
            divz_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= cnt_load_d;
                        op_q    <= mdop;
                        divz_q  <= divisor_zero & mdop[1];
                    end
                end
                RUN: begin
                    // A second start cannot be queued; it is dropped and flagged.
                    if (start) seq_err_q <= 1'b1;
                    if (mt_we || last_d) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state_q == RUN);
    assign result_we = busy && last_d && !divz_q && !mt_we;
    assign seq_err   = seq_err_q;

    // Stall through the final busy cycle so a dependent mfhi/mflo sees updated HI/LO.
    assign md_stall  = (start | busy) & usemd_d;
    assign stall_f   = hazard_stall | md_stall;
    assign stall_d   = hazard_stall | md_stall;
    assign bubble_e  = hazard_stall | md_stall;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl: latency, stall merging, abort, divide-by-zero and error paths.
module tb_md_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mdop = 2'b00;
    logic       divisor_zero = 1'b0;
    logic       mt_we = 1'b0;
    logic       usemd_d = 1'b0;
    logic       hazard_stall = 1'b0;
    logic       busy, result_we, stall_f, stall_d, bubble_e, seq_err;
    logic [1:0] op_q;

    int nvec = 0;
    int nerr = 0;

    md_seq_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .mdop(mdop), .divisor_zero(divisor_zero),
        .mt_we(mt_we), .usemd_d(usemd_d), .hazard_stall(hazard_stall),
        .busy(busy), .result_we(result_we), .op_q(op_q),
        .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs set here apply to the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
        #1;
        nvec++; if (busy !== 1'b0)      begin nerr++; $display("FAIL reset_busy got %b exp 0", busy); end
        nvec++; if (result_we !== 1'b0) begin nerr++; $display("FAIL reset_rwe got %b exp 0", result_we); end
        nvec++; if (stall_f !== 1'b0)   begin nerr++; $display("FAIL reset_stall_f got %b exp 0", stall_f); end
        nvec++; if (stall_d !== 1'b0)   begin nerr++; $display("FAIL reset_stall_d got %b exp 0", stall_d); end
        nvec++; if (bubble_e !== 1'b0)  begin nerr++; $display("FAIL reset_bubble_e got %b exp 0", bubble_e); end
        nvec++; if (seq_err !== 1'b0)   begin nerr++; $display("FAIL reset_seq_err got %b exp 0", seq_err); end
        nvec++; if (op_q !== 2'b00)     begin nerr++; $display("FAIL reset_op_q got %b exp 00", op_q); end
    endtask

    task automatic test_mult();
        logic eb, er;
        start = 1'b1; mdop = 2'b00;
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mult_busy_t0 got %b exp 0", busy); end
        for (int k = 1; k <= 7; k++) begin
            step();
            start = 1'b0;
            #1;
            eb = (k <= 5);
            er = (k == 5);
            nvec++; if (busy !== eb)      begin nerr++; $display("FAIL mult_busy k=%0d got %b exp %b", k, busy, eb); end
            nvec++; if (result_we !== er) begin nerr++; $display("FAIL mult_rwe k=%0d got %b exp %b", k, result_we, er); end
            if (k == 1) begin
                nvec++; if (op_q !== 2'b00) begin nerr++; $display("FAIL mult_op_q got %b exp 00", op_q); end
            end
        end
    endtask

    task automatic test_div_dependent();
        logic es, er;
        start = 1'b1; mdop = 2'b11; divisor_zero = 1'b0; usemd_d = 1'b1;
        #1;
        nvec++; if (stall_f !== 1'b1) begin nerr++; $display("FAIL div_stall_t0 got %b exp 1", stall_f); end
        for (int k = 1; k <= 11; k++) begin
            step();
            start = 1'b0;
            #1;
            es = (k <= 10);
            er = (k == 10);
            nvec++; if (stall_f !== es)   begin nerr++; $display("FAIL div_stall_f k=%0d got %b exp %b", k, stall_f, es); end
            nvec++; if (stall_d !== es)   begin nerr++; $display("FAIL div_stall_d k=%0d got %b exp %b", k, stall_d, es); end
            nvec++; if (bubble_e !== es)  begin nerr++; $display("FAIL div_bubble_e k=%0d got %b exp %b", k, bubble_e, es); end
            nvec++; if (result_we !== er) begin nerr++; $display("FAIL div_rwe k=%0d got %b exp %b", k, result_we, er); end
            if (k == 1) begin
                nvec++; if (op_q !== 2'b11) begin nerr++; $display("FAIL div_op_q got %b exp 11", op_q); end
            end
        end
        usemd_d = 1'b0;
    endtask

    task automatic test_divzero();
        logic eb;
        start = 1'b1; mdop = 2'b10; divisor_zero = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            start = 1'b0;
            #1;
            eb = (k <= 10);
            nvec++; if (busy !== eb)        begin nerr++; $display("FAIL divz_busy k=%0d got %b exp %b", k, busy, eb); end
            nvec++; if (result_we !== 1'b0) begin nerr++; $display("FAIL divz_rwe k=%0d got %b exp 0", k, result_we); end
        end
        divisor_zero = 1'b0;
    endtask

    task automatic test_abort();
        logic eb;
        start = 1'b1; mdop = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            step();
            start = 1'b0;
            mt_we = (k == 2);
            #1;
            eb = (k <= 2);
            nvec++; if (busy !== eb)        begin nerr++; $display("FAIL abort_busy k=%0d got %b exp %b", k, busy, eb); end
            nvec++; if (result_we !== 1'b0) begin nerr++; $display("FAIL abort_rwe k=%0d got %b exp 0", k, result_we); end
        end
        mt_we = 1'b0;
        nvec++; if (seq_err !== 1'b0) begin nerr++; $display("FAIL abort_seq_err got %b exp 0", seq_err); end
    endtask

    task automatic test_seq_err();
        logic ee, er, eb;
        start = 1'b1; mdop = 2'b00;
        for (int k = 1; k <= 7; k++) begin
            step();
            start = (k == 2);
            mdop  = (k == 2) ? 2'b10 : 2'b00;
            #1;
            ee = (k >= 3);
            er = (k == 5);
            eb = (k <= 5);
            nvec++; if (seq_err !== ee)   begin nerr++; $display("FAIL seqerr_flag k=%0d got %b exp %b", k, seq_err, ee); end
            nvec++; if (result_we !== er) begin nerr++; $display("FAIL seqerr_rwe k=%0d got %b exp %b", k, result_we, er); end
            nvec++; if (busy !== eb)      begin nerr++; $display("FAIL seqerr_busy k=%0d got %b exp %b", k, busy, eb); end
            nvec++; if (op_q !== 2'b00)   begin nerr++; $display("FAIL seqerr_op_q k=%0d got %b exp 00", k, op_q); end
        end
        mdop = 2'b00;
    endtask

    task automatic test_reset_mid_op();
        clr = 1'b0;
        step();
        clr = 1'b1;
        #1;
        nvec++; if (seq_err !== 1'b0) begin nerr++; $display("FAIL rst_clears_seq_err got %b exp 0", seq_err); end
        start = 1'b1; mdop = 2'b10;
        step(); start = 1'b0;
        step();
        step();
        clr = 1'b0;
        #1;
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
        step();
        clr = 1'b1;
        #1;
        nvec++; if (op_q !== 2'b00) begin nerr++; $display("FAIL rstmid_op_q got %b exp 00", op_q); end
        for (int k = 0; k < 10; k++) begin
            nvec++; if (busy !== 1'b0)      begin nerr++; $display("FAIL rstmid_busy k=%0d got %b exp 0", k, busy); end
            nvec++; if (result_we !== 1'b0) begin nerr++; $display("FAIL rstmid_rwe k=%0d got %b exp 0", k, result_we); end
            step();
        end
        mdop = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic eb, er;
        start = 1'b1; mdop = 2'b00;
        for (int k = 1; k <= 17; k++) begin
            step();
            start = (k == 6);
            mdop  = (k == 6) ? 2'b10 : 2'b00;
            #1;
            eb = (k <= 5) || (k >= 7 && k <= 16);
            er = (k == 5) || (k == 16);
            nvec++; if (busy !== eb)      begin nerr++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, busy, eb); end
            nvec++; if (result_we !== er) begin nerr++; $display("FAIL b2b_rwe k=%0d got %b exp %b", k, result_we, er); end
            if (k == 7) begin
                nvec++; if (op_q !== 2'b10) begin nerr++; $display("FAIL b2b_op_q got %b exp 10", op_q); end
            end
        end
        nvec++; if (seq_err !== 1'b0) begin nerr++; $display("FAIL b2b_seq_err got %b exp 0", seq_err); end
        mdop = 2'b00;
    endtask

    task automatic test_hazard();
        step();
        usemd_d = 1'b1;
        #1;
        nvec++; if (stall_f !== 1'b0) begin nerr++; $display("FAIL haz_idle_usemd got %b exp 0", stall_f); end
        usemd_d = 1'b0;
        hazard_stall = 1'b1;
        #1;
        nvec++; if (stall_f !== 1'b1)  begin nerr++; $display("FAIL haz_stall_f got %b exp 1", stall_f); end
        nvec++; if (stall_d !== 1'b1)  begin nerr++; $display("FAIL haz_stall_d got %b exp 1", stall_d); end
        nvec++; if (bubble_e !== 1'b1) begin nerr++; $display("FAIL haz_bubble_e got %b exp 1", bubble_e); end
        nvec++; if (busy !== 1'b0)     begin nerr++; $display("FAIL haz_busy got %b exp 0", busy); end
        hazard_stall = 1'b0;
        #1;
        nvec++; if (stall_f !== 1'b0) begin nerr++; $display("FAIL haz_release got %b exp 0", stall_f); end
    endtask

    initial begin
        test_reset();
        step();
        test_mult();
        step();
        test_div_dependent();
        step();
        test_divzero();
        step();
        test_abort();
        step();
        test_seq_err();
        test_reset_mid_op();
        test_back_to_back();
        test_hazard();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
